mul8_dot_acc: RTL and testbench
===============================

Name: mul8_dot_acc

Overview:
- Sequential consumer of the 8x8 unsigned combinational multiplier's 16-bit product.
- Accepts a stream of 8-bit operand pairs over a valid/ready handshake and multiplies each pair internally.
- Accumulates the products into a dot-product and emits one result per vector, terminated by in_last.
- Sits between the operand-fetch logic and the result writeback.

Parameters:
ACC_W, 24, accumulator and result width in bits; legal range 16..32.
MAX_LEN, 256, maximum beats per vector; CNT_W = clog2(MAX_LEN+1).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-high.
in_valid  in  1  operand pair valid.
in_ready  out  1  block can accept an operand pair.
in_a  in  8  unsigned operand A.
in_b  in  8  unsigned operand B.
in_last  in  1  marks the final beat of a vector.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_data  out  ACC_W  dot-product result.
out_count  out  CNT_W  number of beats in the vector.
out_ovf  out  1  accumulation overflowed ACC_W.
out_trunc  out  1  vector closed at MAX_LEN without in_last.

Behaviour:
- Reset (rst=1 at an edge): state ACCUM. acc=0, cnt=0, ovf=0. Pipeline valids cleared.
- Reset output values: in_ready=0 during the rst cycle, otherwise following state rules; out_valid=0, out_data=0, out_count=0, out_ovf=0, out_trunc=0.
- Handshake: a beat transfers on an edge with in_valid&in_ready. A result transfers on out_valid&out_ready.
- Inputs and outputs are registered.
- Pipeline:
  - P1 registers a, b, last, trunc and a valid bit.
  - P2 registers prod = a*b (16 bit, unsigned, exact) with the same side bits.
  - The accumulator adds P2.prod, zero-extended to ACC_W+1 bits, at the next edge.
- Latency: last beat accepted at edge E0 -> P1 after E0 -> P2 after E1 -> out_valid=1 after E2.
- FSM states:
  - ACCUM: in_ready=1. A beat with in_last=1, or the beat where cnt+1==MAX_LEN, moves to DRAIN. That beat's trunc = ~in_last.
  - DRAIN: in_ready=0. Wait for the closing beat to leave P2. At that edge, load out_data=acc+prod, out_count=cnt, out_ovf, out_trunc, out_valid=1, then go to OUT.
  - OUT: in_ready=0. out_* held stable while out_ready=0. On the handshake edge: clear out_valid, acc, cnt and ovf, and return to ACCUM.
- No overlap between vectors. The first beat of the next vector is accepted no earlier than the edge after the result handshake.
- cnt increments on each accepted beat. out_count ranges 1..MAX_LEN.
- Overflow: ovf is sticky within a vector. It sets when the ACC_W+1-bit sum carries out of ACC_W.
- Result wrap/saturation is governed by the optional feature.
- in_a, in_b and in_last are ignored when in_ready=0 or in_valid=0.
- out_ready is ignored when out_valid=0.
- A single-beat vector is legal: out_count=1.
- rst mid-vector or mid-OUT aborts immediately. The partial vector is discarded and no result is emitted.

Optional Feature:
- Macro: MUL8_DOT_ACC_SAT_EN.
- Defined: on overflow, acc clamps to 2^ACC_W-1 and stays clamped for the rest of the vector. out_data = 2^ACC_W-1 and out_ovf=1.
- Undefined: acc wraps modulo 2^ACC_W. out_ovf still reports the sticky carry-out.

Test Plan:
- Single beat a=255, b=255, last=1 -> out_valid 3 cycles later; out_data=65025, out_count=1, out_ovf=0, out_trunc=0.
- Vector (1,2),(3,4),(5,6), last on the third beat, one beat per cycle -> out_data=44, out_count=3; in_ready=0 from the edge after the third beat until the handshake.
- out_ready held 0 for 5 cycles while out_valid=1 -> out_data, out_count and out_valid stable; in_ready=0; beats offered meanwhile are not consumed.
- ACC_W=16, vector (255,255),(255,255) -> without SAT_EN: out_data=64514, out_ovf=1; with SAT_EN: out_data=65535, out_ovf=1.
- MAX_LEN=4, five beats (1,1) with in_last=0 -> result after the fourth beat: out_data=4, out_count=4, out_trunc=1; the fifth beat is accepted only after the handshake.
- rst asserted one cycle after accepting beat 2 of a 3-beat vector -> no out_valid; after reset, vector (2,3) last -> out_data=6, out_count=1.

Source files
------------

// File: rtl/mul8_dot_acc.sv
// Purpose: streaming 8x8 unsigned multiply-accumulate; one dot-product result per in_last-terminated vector.
// Latency: closing beat accepted at edge E0 -> out_valid after E2 (P1, P2, then accumulate/load).
// Backpressure: in_ready low from closing beat until result handshake; out_* held while out_ready=0.
// Optional feature: define MUL8_DOT_ACC_SAT_EN to saturate the accumulator on overflow (default wraps).
module mul8_dot_acc #(
  parameter int ACC_W = 24,
  parameter int MAX_LEN = 256,
  localparam int CNT_W = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_trunc
);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Vector bookkeeping
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  // Pipeline stage 1: raw operands
  logic             p1_vld;
  logic [7:0]       p1_a;
  logic [7:0]       p1_b;
  logic             p1_last;
  logic             p1_trunc;

  // Pipeline stage 2: exact product
  logic             p2_vld;
  logic [15:0]      p2_prod;
  logic             p2_last;
  logic             p2_trunc;

  logic             accept;
  logic             hit_max;
  logic             p2_close;
  logic             close_load;
  logic             out_hs;
  logic [ACC_W:0]   sum;
  logic             ovf_nxt;
  logic [ACC_W-1:0] acc_nxt;

  assign accept   = in_valid & in_ready;
  // The beat that fills the vector to MAX_LEN closes it even without in_last.
  assign hit_max  = (cnt + CNT_W'(1)) == CNT_W'(MAX_LEN);
  assign p2_close = p2_last | p2_trunc;
  assign close_load = (state == DRAIN) & p2_vld & p2_close;
  assign out_hs   = out_valid & out_ready;

  // One extra bit on the adder exposes the carry-out of ACC_W for overflow detection.
  assign sum     = {1'b0, acc} + {{(ACC_W - 15){1'b0}}, p2_prod};
  assign ovf_nxt = ovf | sum[ACC_W];

`ifdef MUL8_DOT_ACC_SAT_EN
  // Once overflowed, the accumulator pins at full scale for the rest of the vector.
  assign acc_nxt = ovf_nxt ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_nxt = sum[ACC_W-1:0];
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  // Next-state and in_ready decode; in_ready is forced low while reset is asserted.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = ~rst;
        if (in_valid && !rst && (in_last || hit_max)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (p2_vld && p2_close) state_nxt = OUT;
      end
      OUT: begin
        if (out_hs) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // Two-stage operand/product pipeline; side bits travel with the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_vld   <= 1'b0;
      p1_a     <= '0;
      p1_b     <= '0;
      p1_last  <= 1'b0;
      p1_trunc <= 1'b0;
      p2_vld   <= 1'b0;
      p2_prod  <= '0;
      p2_last  <= 1'b0;
      p2_trunc <= 1'b0;
    end else begin
      p1_vld <= accept;
      if (accept) begin
        p1_a     <= in_a;
        p1_b     <= in_b;
        p1_last  <= in_last;
        p1_trunc <= hit_max & ~in_last;
      end
      p2_vld <= p1_vld;
      if (p1_vld) begin
        p2_prod  <= p1_a * p1_b;
        p2_last  <= p1_last;
        p2_trunc <= p1_trunc;
      end
    end
  end

  // Accumulate products, load the result on the closing beat, clear on result handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
      out_trunc <= 1'b0;
    end else begin
      if (accept) cnt <= cnt + CNT_W'(1);
      if (p2_vld) begin
        acc <= acc_nxt;
        ovf <= ovf_nxt;
      end
      if (close_load) begin
        out_valid <= 1'b1;
        out_data  <= acc_nxt;
        out_count <= cnt;
        out_ovf   <= ovf_nxt;
        out_trunc <= p2_trunc;
      end
      if ((state == OUT) && out_hs) begin
        out_valid <= 1'b0;
        acc       <= '0;
        cnt       <= '0;
        ovf       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mul8_dot_acc.sv
// Directed bench for mul8_dot_acc with ACC_W=16, MAX_LEN=4.
// Covers reset, latency, stall, overflow (wrap or saturate), truncation and mid-vector reset.
module tb_mul8_dot_acc;

  localparam int ACC_W   = 16;
  localparam int MAX_LEN = 4;
  localparam int CNT_W   = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  logic             out_trunc;

  int checks = 0;
  int errors = 0;

  mul8_dot_acc #(.ACC_W(ACC_W), .MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ovf   (out_ovf),
    .out_trunc (out_trunc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Offer one beat and hold it until accepted (bounded), then drop in_valid.
  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic last);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) break;
      @(posedge clk); #1;
    end
    chk("send_rdy", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_vld();
    for (int i = 0; i < 50; i++) begin
      if (out_valid) break;
      @(posedge clk); #1;
    end
    chk("res_vld", out_valid, 1);
  endtask

  // Wait for a result, check all fields, then complete the handshake.
  task automatic get_result(input logic [31:0] d, input logic [31:0] c,
                            input logic [31:0] o, input logic [31:0] t);
    wait_vld();
    chk("res_data", out_data, d);
    chk("res_count", out_count, c);
    chk("res_ovf", out_ovf, o);
    chk("res_trunc", out_trunc, t);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("res_clr", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_out_trunc", out_trunc, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", in_ready, 1);

    // Single beat 255*255: out_valid exactly after the second edge following acceptance
    send_beat(8'd255, 8'd255, 1'b1);
    chk("t1_rdy_drain", in_ready, 0);
    chk("t1_lat0", out_valid, 0);
    @(posedge clk); #1;
    chk("t1_lat1", out_valid, 0);
    @(posedge clk); #1;
    chk("t1_lat2", out_valid, 1);
    get_result(65025, 1, 0, 0);
    chk("t1_rdy_back", in_ready, 1);

    // Three-beat vector with a 5-cycle output stall; offered beats must not be taken
    send_beat(8'd1, 8'd2, 1'b0);
    send_beat(8'd3, 8'd4, 1'b0);
    send_beat(8'd5, 8'd6, 1'b1);
    chk("t2_rdy_low", in_ready, 0);
    wait_vld();
    in_valid = 1'b1;
    in_a     = 8'd9;
    in_b     = 8'd9;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_vld", out_valid, 1);
      chk("stall_data", out_data, 44);
      chk("stall_count", out_count, 3);
      chk("stall_rdy", in_ready, 0);
    end
    in_valid = 1'b0;
    get_result(44, 3, 0, 0);
    send_beat(8'd2, 8'd2, 1'b1);
    get_result(4, 1, 0, 0);

    // Overflow of a 16-bit accumulator: 2*65025 = 130050
    send_beat(8'd255, 8'd255, 1'b0);
    send_beat(8'd255, 8'd255, 1'b1);
`ifdef MUL8_DOT_ACC_SAT_EN
    get_result(65535, 2, 1, 0);
`else
    get_result(64514, 2, 1, 0);
`endif

    // Truncation at MAX_LEN=4; fifth beat waits until after the handshake
    for (int i = 0; i < 4; i++) send_beat(8'd1, 8'd1, 1'b0);
    chk("t5_rdy_low", in_ready, 0);
    in_valid = 1'b1;
    in_a     = 8'd1;
    in_b     = 8'd1;
    in_last  = 1'b0;
    @(posedge clk); #1;
    chk("t5_hold_rdy", in_ready, 0);
    get_result(4, 4, 0, 1);
    send_beat(8'd1, 8'd1, 1'b0);
    send_beat(8'd1, 8'd1, 1'b1);
    get_result(2, 2, 0, 0);

    // Reset one cycle after beat 2 of a 3-beat vector: no result emerges
    send_beat(8'd7, 8'd7, 1'b0);
    send_beat(8'd7, 8'd7, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_mid_rdy", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("rst_no_vld", out_valid, 0);
    end
    send_beat(8'd2, 8'd3, 1'b1);
    get_result(6, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
